// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding and
// iteration constants used by div_iter and its datapath step.
package div_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+2:0] trial;

  // The extra top bit of trial is a pure borrow flag, so a large shifted value
  // (possible only when dividing by zero) never reads as negative.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    trial   = {1'b0, shifted} - {3'b000, divisor};
    q_bit   = ~trial[WIDTH+2];
    rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: 32 iterations on operand
// magnitudes, then sign fixup into registered quotient s and remainder r.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             exception,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             complete,
  output logic             busy
);

  // Handshake: the requester raises div with operands valid and holds it until
  // it sees complete (one cycle, s/r valid then). Dropping div or raising
  // exception while busy abandons the op; a new op needs div high in IDLE.

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] r_q;

  logic [WIDTH-1:0] abs_x;
  logic [WIDTH-1:0] abs_y;
  logic             y_zero;
  logic             start;
  logic             abort;
  logic             last_iter;
  logic             finish;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] rem_final;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (dvd_q[WIDTH-1]),
    .divisor      (dvs_q),
    .rem_out      (step_rem),
    .q_bit        (step_bit)
  );

  always_comb begin
    abs_x     = (div_signed && x[WIDTH-1]) ? -x : x;
    abs_y     = (div_signed && y[WIDTH-1]) ? -y : y;
    y_zero    = (y == '0);
    start     = (state_q == IDLE) && div && !exception;
    abort     = (state_q == BUSY) && (exception || !div);
    last_iter = (state_q == BUSY) && (cnt_q == CNT_W'(DIV_ITERS - 1));
    finish    = last_iter && !abort;
    // Quotient bits shift into the low end of the dividend register.
    q_final   = {dvd_q[WIDTH-2:0], step_bit};
    rem_final = step_rem[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (div && !exception) state_d = BUSY;
      end
      BUSY: begin
        if (exception || !div) state_d = IDLE;
        else if (last_iter)    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      s_q      <= '0;
      r_q      <= '0;
    end else begin
      if (start) begin
        cnt_q    <= '0;
        rem_q    <= '0;
        dvd_q    <= abs_x;
        dvs_q    <= abs_y;
        // A zero divisor yields all-ones quotient with no sign fixup; the
        // remainder path already reproduces x since -|x| == x for negative x.
        sign_q_q <= div_signed && (x[WIDTH-1] ^ y[WIDTH-1]) && !y_zero;
        sign_r_q <= div_signed && x[WIDTH-1];
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
        rem_q <= step_rem;
        dvd_q <= q_final;
      end
      if (finish) begin
        s_q <= sign_q_q ? -q_final : q_final;
        r_q <= sign_r_q ? -rem_final : rem_final;
      end
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign complete = (state_q == DONE);
  assign busy     = (state_q == BUSY);

endmodule
